// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with prefetch queue, redirect flush and halt detection
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready/addr    fetch request to instruction memory
//   imem_rsp_valid/data          in-order responses, one per accepted request
//   redirect_valid/pc            one-cycle redirect from execute
//   dec_valid/ready/instr/pc     queue head handed to decode
//   pc                           current fetch PC
//   hlt                          sticky halt, cleared only by reset
module fetch_unit #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_INC  = 2,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               hlt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_addr  [DEPTH];
    logic [ADDR_W-1:0]  a_fifo  [DEPTH];   // PCs of accepted requests, oldest at a_head
    logic [PTR_W-1:0]   q_head, q_tail, a_head, a_tail;
    logic [CNT_W-1:0]   count, outstanding, drop, out_next;
    logic               halt_pending;

    logic redir, credit, req_fire, rsp_take, rsp_push, pop;

    // A redirect after halt is ignored entirely.
    assign redir    = redirect_valid & ~hlt;
    // Queue slots are reserved for every in-flight request so a response always has room.
    assign credit   = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
    // Gated by rst_n so the request line is low while reset is held.
    assign imem_req_valid = rst_n & ~redirect_valid & ~halt_pending & ~hlt & credit;
    assign imem_req_addr  = fetch_pc;
    assign pc             = fetch_pc;

    assign req_fire = imem_req_valid & imem_req_ready;
    // Responses with nothing outstanding are stale (e.g. from before reset).
    assign rsp_take = imem_rsp_valid & (outstanding != '0);
    assign rsp_push = rsp_take & (drop == '0) & ~redir;

    assign dec_valid = (count != '0) & ~redirect_valid & ~hlt;
    assign dec_instr = q_instr[q_head];
    assign dec_pc    = q_addr[q_head];
    assign pop       = dec_valid & dec_ready;

    assign out_next  = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= '0;
            q_head       <= '0;
            q_tail       <= '0;
            a_head       <= '0;
            a_tail       <= '0;
            count        <= '0;
            outstanding  <= '0;
            drop         <= '0;
            halt_pending <= 1'b0;
            hlt          <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_instr[i] <= '0;
                q_addr[i]  <= '0;
                a_fifo[i]  <= '0;
            end
        end else begin
            outstanding <= out_next;
            if (req_fire) begin
                a_fifo[a_tail] <= fetch_pc;
                a_tail         <= a_tail + 1'b1;
            end
            if (rsp_take) begin
                a_head <= a_head + 1'b1;
            end
            if (redir) begin
                // Everything still in flight after this edge belongs to the old stream.
                fetch_pc     <= redirect_pc;
                q_head       <= '0;
                q_tail       <= '0;
                count        <= '0;
                drop         <= out_next;
                halt_pending <= 1'b0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                end
                if (rsp_take && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (rsp_push) begin
                    q_instr[q_tail] <= imem_rsp_data;
                    q_addr[q_tail]  <= a_fifo[a_head];
                    q_tail          <= q_tail + 1'b1;
                    if (imem_rsp_data[INSTR_W-1 -: 4] == HALT_OP) begin
                        halt_pending <= 1'b1;
                    end
                end
                if (pop) begin
                    q_head <= q_head + 1'b1;
                    if (q_instr[q_head][INSTR_W-1 -: 4] == HALT_OP) begin
                        hlt <= 1'b1;
                    end
                end
                count <= count + CNT_W'(rsp_push) - CNT_W'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a queue-based reference model
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [3:0] HALT = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [15:0] dec_instr, dec_pc, pc;
    logic        hlt;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .pc(pc), .hlt(hlt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] instr; logic [15:0] addr; } entry_t;
    typedef struct packed { logic [15:0] addr; logic drop; } fl_t;
    typedef struct { logic [15:0] addr; int due; } mreq_t;

    // reference model state
    entry_t      m_q[$];
    fl_t         m_fl[$];
    logic [15:0] m_pc;
    logic        m_hp, m_hlt;

    // memory environment
    mreq_t       mem_q[$];
    int          last_due;
    logic [15:0] halt_at;
    int          lat_min, lat_max, req_pct, dec_pct;
    logic        stale;

    // stimulus controls and observation logs
    logic        redir_next;
    logic [15:0] redir_tgt;
    int          cyc;
    logic [15:0] reqs[$];
    logic [15:0] pops[$];
    logic        last_rv, last_dv, last_hlt;
    logic [15:0] last_di;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == halt_at) ? 16'hF000 : 16'h1000 + a;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0; redirect_pc = 16'h0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", 32'(imem_req_addr), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", 32'(dec_instr), 32'd0);
        chk("rst_dec_pc", 32'(dec_pc), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_hlt", 32'(hlt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_q.delete(); m_fl.delete(); m_pc = 16'h0; m_hp = 1'b0; m_hlt = 1'b0;
        mem_q.delete(); last_due = -1; cyc = 0; stale = 1'b1; redir_next = 1'b0;
    endtask

    // Called just after a rising edge; drives one cycle, checks mid-cycle, advances the model.
    task automatic cycle();
        logic exp_rv, exp_dv, redir_now, from_mem;
        entry_t e;
        fl_t f;
        int lat, due;
        imem_req_ready = ($urandom_range(0, 99) < req_pct);
        dec_ready      = ($urandom_range(0, 99) < dec_pct);
        redirect_valid = redir_next;
        redirect_pc    = redir_tgt;
        redir_next     = 1'b0;
        from_mem       = 1'b0;
        if (stale) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = 16'hF0F0; stale = 1'b0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_q[0].addr); from_mem = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0; imem_rsp_data = 16'($urandom);
        end
        #4;
        exp_rv = !redirect_valid && !m_hp && !m_hlt && ((m_q.size() + m_fl.size()) < DEPTH);
        exp_dv = (m_q.size() > 0) && !redirect_valid && !m_hlt;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", 32'(imem_req_addr), 32'(m_pc));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
        chk("hlt", 32'(hlt), 32'(m_hlt));
        if (exp_dv) begin
            chk("dec_pc", 32'(dec_pc), 32'(m_q[0].addr));
            chk("dec_instr", 32'(dec_instr), 32'(m_q[0].instr));
        end
        last_rv = imem_req_valid; last_dv = dec_valid; last_hlt = hlt; last_di = dec_instr;
        if (from_mem) void'(mem_q.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{imem_req_addr, due});
            reqs.push_back(imem_req_addr);
        end
        if (dec_valid && dec_ready) pops.push_back(dec_pc);
        @(posedge clk);
        redir_now = redirect_valid && !m_hlt;
        if (exp_dv && dec_ready) begin
            e = m_q.pop_front();
            if (e.instr[15:12] == HALT) m_hlt = 1'b1;
        end
        if (imem_rsp_valid && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!f.drop && !redir_now) begin
                m_q.push_back({imem_rsp_data, f.addr});
                if (imem_rsp_data[15:12] == HALT) m_hp = 1'b1;
            end
        end
        if (exp_rv && imem_req_ready) begin
            m_fl.push_back({m_pc, 1'b0});
            m_pc = m_pc + 16'd2;
        end
        if (redir_now) begin
            m_q.delete();
            foreach (m_fl[i]) m_fl[i].drop = 1'b1;
            m_pc = redirect_pc;
            m_hp = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b1;
        imem_req_ready = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0;
        halt_at = 16'hFFFF; lat_min = 1; lat_max = 1; req_pct = 100; dec_pct = 100;
        redir_next = 1'b0; redir_tgt = 16'h0;
        @(posedge clk);
        #1;

        // 1: streaming with 1-cycle memory
        do_reset();
        cycle();
        chk("t1_first_req_valid", 32'(last_rv), 32'd1);
        cycle();
        chk("t1_cycle1_dec_valid", 32'(last_dv), 32'd0);
        pops.delete();
        cycle();
        chk("t1_cycle2_dec_valid", 32'(last_dv), 32'd1);
        chk("t1_first_instr", 32'(last_di), 32'h1000);
        run(10);
        chk("t1_sustained_pops", 32'(pops.size()), 32'd11);
        chk("t1_third_pc", 32'(pops[2]), 32'h0004);

        // 2: backpressure fills the queue, then drains in order
        do_reset();
        dec_pct = 0; reqs.delete(); pops.delete();
        run(8);
        chk("t2_req_count_full", 32'(reqs.size()), 32'd4);
        chk("t2_req_valid_full", 32'(last_rv), 32'd0);
        chk("t2_head_hold", 32'(last_di), 32'h1000);
        dec_pct = 100;
        run(10);
        chk("t2_drain0", 32'(pops[0]), 32'h0000);
        chk("t2_drain3", 32'(pops[3]), 32'h0006);
        chk("t2_resume_addr", 32'(reqs[4]), 32'h0008);

        // 3: redirect with two responses in flight and one queued
        do_reset();
        lat_min = 3; lat_max = 3; dec_pct = 0; req_pct = 100;
        run(3);
        req_pct = 0;
        run(1);
        redir_next = 1'b1; redir_tgt = 16'h0040; pops.delete();
        cycle();
        chk("t3_redirect_dec_valid", 32'(last_dv), 32'd0);
        req_pct = 100; dec_pct = 100;
        run(12);
        chk("t3_first_after_redirect", 32'(pops[0]), 32'h0040);

        // 4: halt word at address 6
        do_reset();
        lat_min = 1; lat_max = 1; halt_at = 16'h0006; pops.delete();
        run(15);
        chk("t4_hlt", 32'(last_hlt), 32'd1);
        chk("t4_req_blocked", 32'(last_rv), 32'd0);
        chk("t4_pop_count", 32'(pops.size()), 32'd4);
        chk("t4_last_pop", 32'(pops[3]), 32'h0006);

        // 5: redirect cancels a pending halt
        do_reset();
        dec_pct = 0;
        run(7);
        redir_next = 1'b1; redir_tgt = 16'h0100; pops.delete();
        cycle();
        dec_pct = 100;
        run(12);
        chk("t5_hlt_clear", 32'(last_hlt), 32'd0);
        chk("t5_resume_pc", 32'(pops[0]), 32'h0100);
        halt_at = 16'hFFFF;

        // 6: PC wrap, then reset mid-burst with a stale response afterwards
        do_reset();
        redir_next = 1'b1; redir_tgt = 16'hFFFC; reqs.delete();
        run(6);
        chk("t6_pre_wrap", 32'(reqs[1]), 32'hFFFE);
        chk("t6_wrap", 32'(reqs[2]), 32'h0000);
        do_reset();
        reqs.delete(); pops.delete();
        run(6);
        chk("t6_restart_addr", 32'(reqs[0]), 32'h0000);
        chk("t6_restart_pop", 32'(pops[0]), 32'h0000);
        chk("t6_stale_no_hlt", 32'(last_hlt), 32'd0);

        // randomized segments
        for (int s = 0; s < 10; s++) begin
            do_reset();
            lat_min = int'($urandom_range(1, 2));
            lat_max = lat_min + int'($urandom_range(0, 3));
            req_pct = int'($urandom_range(40, 100));
            dec_pct = int'($urandom_range(30, 100));
            halt_at = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 32) * 2) : 16'hFFFF;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 99) < 4) begin
                    redir_next = 1'b1;
                    redir_tgt  = 16'($urandom_range(0, 16'h3FFF)) & 16'hFFFE;
                end
                cycle();
            end
        end
        halt_at = 16'hFFFF;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
